// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and select helpers for mux_2x1.
// Helpers work on N_MAX-bit vectors; callers zero-extend narrower selects.
package mux_pkg;

  localparam int N_DEFAULT = 4;
  localparam int N_MAX     = 32;

  typedef logic [N_MAX-1:0] sel_wide_t;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic sel_wide_t lowest_onehot(
    input sel_wide_t sel
  );
    return sel & (-sel);
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(
    input sel_wide_t sel
  );
    return (sel != '0) &&
           ((sel & (sel - sel_wide_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/mux_aor_slice.sv
// mux_aor_slice: masked AND-OR reduction select.
// Ports: a (data), sel (select), y (lowest-selected bit of a, 0 if sel==0).
module mux_aor_slice
  import mux_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] sel,
  output logic         y
);

  logic [N-1:0] mask;

  // Keep only the lowest set select bit so multi-hot
  // resolves the same way as the priority styles.
  assign mask = sel & (~sel + N'(1));
  assign y    = |(a & mask);

endmodule

// File: rtl/mux_2x1.sv
// mux_2x1: one-hot select mux in five coding styles plus registered bit/error.
// Ports: clk_i, rst_i (async high), a_i, sel_i -> y_*_o, y_q_o, sel_err_o.
// Optional: define MUX_ASSERT_EN for simulation cross-check assertions.
module mux_2x1
  import mux_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] sel_i,
  output logic         y_ter_o,
  output logic         y_case_o,
  output logic         y_ifelse_o,
  output logic         y_loop_o,
  output logic         y_aor_o,
  output logic         y_q_o,
  output logic         sel_err_o
);

  if (N < 2 || N > N_MAX) begin : g_bad_n
    $error("mux_2x1: N out of range");
  end

  // Ternary chain: stage k falls through to k+1,
  // so the lowest selected bit wins.
  logic [N:0] ter_chain;

  assign ter_chain[N] = 1'b0;

  for (genvar k = 0; k < N; k++) begin : g_ter
    assign ter_chain[k] =
      sel_i[k] ? a_i[k] : ter_chain[k+1];
  end

  assign y_ter_o = ter_chain[0];

  // Case: one-hot values enumerated; the fallback
  // handles zero and multi-hot by priority.
  logic case_hit;

  always_comb begin
    y_case_o = 1'b0;
    case_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      case (sel_i)
        (N'(1) << k): begin
          y_case_o = a_i[k];
          case_hit = 1'b1;
        end
        default: ;
      endcase
    end
    if (!case_hit) begin
      y_case_o = |(N_MAX'(a_i) &
        lowest_onehot(N_MAX'(sel_i)));
    end
  end

  // If/else-if chain, lowest index tested first.
  logic if_found;

  always_comb begin
    y_ifelse_o = 1'b0;
    if_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (if_found) begin
        if_found = 1'b1;
      end else if (sel_i[k]) begin
        y_ifelse_o = a_i[k];
        if_found   = 1'b1;
      end
    end
  end

  // Loop: descending, so the lowest k writes last.
  always_comb begin
    y_loop_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (sel_i[k]) begin
        y_loop_o = a_i[k];
      end
    end
  end

  mux_aor_slice #(
    .N (N)
  ) u_aor (
    .a   (a_i),
    .sel (sel_i),
    .y   (y_aor_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q_o     <= 1'b0;
      sel_err_o <= 1'b0;
    end else begin
      y_q_o     <= y_ter_o;
      sel_err_o <= !is_onehot(N_MAX'(sel_i));
    end
  end

`ifdef MUX_ASSERT_EN
  always @(a_i or sel_i) begin
    #0;
    assert ((y_ter_o == y_case_o) &&
            (y_ter_o == y_ifelse_o) &&
            (y_ter_o == y_loop_o) &&
            (y_ter_o == y_aor_o))
      else $error("mux_2x1: styles disagree");
  end

  property p_sel_err;
    @(posedge clk_i) disable iff (rst_i)
      !$past(rst_i) |->
        (sel_err_o == !$past($onehot(sel_i)));
  endproperty

  a_sel_err: assert property (p_sel_err)
    else $error("mux_2x1: sel_err_o wrong");
`else
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: directed self-checking bench for mux_2x1.
// Five comb outputs are packed into ys for comparison.
module tb_mux_2x1;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] a_i;
  logic [3:0] sel_i;
  logic       y_ter_o;
  logic       y_case_o;
  logic       y_ifelse_o;
  logic       y_loop_o;
  logic       y_aor_o;
  logic       y_q_o;
  logic       sel_err_o;
  logic [4:0] ys;

  int errors = 0;
  int checks = 0;

  mux_2x1 #(
    .N (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_i        (a_i),
    .sel_i      (sel_i),
    .y_ter_o    (y_ter_o),
    .y_case_o   (y_case_o),
    .y_ifelse_o (y_ifelse_o),
    .y_loop_o   (y_loop_o),
    .y_aor_o    (y_aor_o),
    .y_q_o      (y_q_o),
    .sel_err_o  (sel_err_o)
  );

  assign ys = {y_ter_o, y_case_o, y_ifelse_o,
               y_loop_o, y_aor_o};

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Priority reference: lowest set select bit wins.
  function automatic logic prio_ref(
    input logic [3:0] a,
    input logic [3:0] s
  );
    for (int k = 0; k < 4; k++) begin
      if (s[k]) return a[k];
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    a_i   = 4'b0001;
    sel_i = 4'b0001;
    @(posedge clk_i);
    #1;
    checks++;
    if (y_q_o !== 1'b0 || sel_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: y_q=%b err=%b want 0 0",
               y_q_o, sel_err_o);
    end
    checks++;
    if (ys !== 5'b11111) begin
      errors++;
      $display("FAIL reset_comb: ys=%b want 11111", ys);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_onehot();
    logic [3:0] sels [4];
    logic [4:0] exp  [4];
    sels = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp  = '{5'b00000, 5'b11111, 5'b00000, 5'b11111};
    a_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      sel_i = sels[i];
      #1;
      checks++;
      if (ys !== exp[i]) begin
        errors++;
        $display("FAIL onehot sel=%b: ys=%b want %b",
                 sel_i, ys, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int unsigned k;
    logic exp;
    for (int i = 0; i < 10; i++) begin
      a_i   = 4'($urandom_range(15));
      k     = $urandom_range(3);
      sel_i = 4'b0001 << k;
      #5;
      exp = a_i[k];
      checks++;
      if (ys !== {5{exp}}) begin
        errors++;
        $display("FAIL random a=%b sel=%b: ys=%b want %b",
                 a_i, sel_i, ys, {5{exp}});
      end
    end
  endtask

  task automatic test_zero_sel();
    @(negedge clk_i);
    a_i   = 4'hF;
    sel_i = 4'b0000;
    #1;
    checks++;
    if (ys !== 5'b00000) begin
      errors++;
      $display("FAIL zero_sel: ys=%b want 00000", ys);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (sel_err_o !== 1'b1 || y_q_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_sel_reg: err=%b y_q=%b want 1 0",
               sel_err_o, y_q_o);
    end
  endtask

  task automatic test_multi_hot();
    @(negedge clk_i);
    a_i   = 4'b0010;
    sel_i = 4'b0110;
    #1;
    checks++;
    if (ys !== 5'b11111) begin
      errors++;
      $display("FAIL multi_hot: ys=%b want 11111", ys);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (sel_err_o !== 1'b1 || y_q_o !== 1'b1) begin
      errors++;
      $display("FAIL multi_hot_reg: err=%b y_q=%b want 1 1",
               sel_err_o, y_q_o);
    end
    @(negedge clk_i);
    sel_i = 4'b0100;
    #1;
    checks++;
    if (ys !== 5'b00000) begin
      errors++;
      $display("FAIL single_after: ys=%b want 00000", ys);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (sel_err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_after_reg: err=%b want 0",
               sel_err_o);
    end
  endtask

  task automatic test_registered();
    @(negedge clk_i);
    a_i   = 4'b0100;
    sel_i = 4'b0100;
    @(posedge clk_i);
    #1;
    checks++;
    if (y_q_o !== 1'b1) begin
      errors++;
      $display("FAIL reg_load: y_q=%b want 1", y_q_o);
    end
    @(negedge clk_i);
    sel_i = 4'b0000;
    #1;
    @(posedge clk_i);
    #1;
    checks++;
    if (sel_err_o !== 1'b1) begin
      errors++;
      $display("FAIL reg_err_set: err=%b want 1", sel_err_o);
    end
    sel_i = 4'b0100;
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (y_q_o !== 1'b0 || sel_err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: y_q=%b err=%b want 0 0",
               y_q_o, sel_err_o);
    end
    checks++;
    if (ys !== 5'b11111) begin
      errors++;
      $display("FAIL rst_comb: ys=%b want 11111", ys);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (y_q_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: y_q=%b want 0", y_q_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (y_q_o !== 1'b1 || sel_err_o !== 1'b0) begin
      errors++;
      $display("FAIL post_rst: y_q=%b err=%b want 1 0",
               y_q_o, sel_err_o);
    end
  endtask

  task automatic test_sweep();
    logic exp;
    for (int av = 0; av < 16; av++) begin
      for (int sv = 0; sv < 16; sv++) begin
        a_i   = 4'(av);
        sel_i = 4'(sv);
        #1;
        exp = prio_ref(a_i, sel_i);
        checks++;
        if (ys !== {5{exp}}) begin
          errors++;
          $display("FAIL sweep a=%b sel=%b: ys=%b want %b",
                   a_i, sel_i, ys, {5{exp}});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_random();
    test_zero_sel();
    test_multi_hot();
    test_registered();
    test_sweep();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- One-hot-select multiplexer that picks one bit of a_i using a one-hot sel_i.
- Contains five independent, functionally identical implementations, each on its own output: ternary, case, if-else, for-loop, AND-OR. These are used for cross-checking coding styles.
- Also provides a registered copy of the selected bit and a registered select-error flag.
- Standalone teaching/reference block; sits directly under a bench or wrapper.

Parameters:
- N, 4, number of data inputs; also the width of a_i and sel_i; must be ≥ 2.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_i  input  1  asynchronous active-high reset.
- a_i  input  N  data bits.
- sel_i  input  N  one-hot select; bit k selects a_i[k].
- y_ter_o  output  1  selected bit, ternary-chain implementation.
- y_case_o  output  1  selected bit, case implementation.
- y_ifelse_o  output  1  selected bit, if/else-if implementation.
- y_loop_o  output  1  selected bit, for-loop implementation.
- y_aor_o  output  1  selected bit, AND-OR reduction implementation.
- y_q_o  output  1  registered selected bit.
- sel_err_o  output  1  registered flag: sel_i was not one-hot.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Combinational outputs (y_ter_o, y_case_o, y_ifelse_o, y_loop_o, y_aor_o):
  - Zero latency; valid in the same delta as any change to a_i or sel_i.
  - Unaffected by clk_i and rst_i.
- One-hot sel_i with bit k set: every combinational output equals a_i[k], i.e. a_i[log2(sel_i)].
- sel_i == 0: every combinational output is 0.
- Multi-hot sel_i: the lowest set bit wins, so all outputs equal a_i[min k with sel_i[k]=1].
  - AND-OR implementation masks first: sel_i & (~sel_i + 1), then reduction-OR of (a_i & mask).
  - The five outputs must agree bit-for-bit for all 2^(2N) input combinations.
- Case implementation: enumerate the one-hot values; default covers zero and multi-hot via the priority rule. No latches.
- Loop implementation: iterate k from N-1 down to 0 so the last assignment (the lowest k) wins; initialise to 0.
- y_q_o: on each rising edge of clk_i, loads the y_ter_o value. One-cycle latency.
- sel_err_o: on each rising edge of clk_i, loads 1 if sel_i is zero or has more than one bit set; otherwise loads 0. One-cycle latency.
- Reset: while rst_i=1, y_q_o=0 and sel_err_o=0 immediately, regardless of clk_i.
  - The first edge after rst_i falls samples normally.
  - Reset asserted mid-operation clears both registers at once; combinational outputs keep tracking inputs.

Optional Feature:
- Macro: MUX_ASSERT_EN.
- When defined: simulation-only immediate assertions, evaluated on every input change after a zero-delay settle, that all five combinational outputs are equal. Concurrent assertion on clk_i (disabled during rst_i) that sel_err_o matches $onehot(sel_i) of the prior cycle; violations raise $error.
- When undefined: no assertion code; ports and logic are identical.

Decomposition:
- Package mux_pkg:
  - N_DEFAULT = 4.
  - Function lowest_onehot(sel), returning sel & -sel.
  - Function is_onehot(sel).
- Natural sub-module: mux_aor_slice (the masked AND-OR reduction), instantiated once. The other four styles stay inline in mux_2x1.

Test Plan:
- a_i=4'b1010, sel_i=4'b0001/0010/0100/1000 -> all five outputs 0/1/0/1 respectively.
- 10 random iterations: a_i uniform 0..15, sel_i = 1<<rand(0..3); after 5 time units every output equals a_i[$clog2(sel_i)].
- sel_i=4'b0000, a_i=4'hF -> all five outputs 0; next rising edge gives sel_err_o=1, y_q_o=0.
- sel_i=4'b0110, a_i=4'b0010 -> all outputs 1 (bit 1 wins); next edge gives sel_err_o=1. Then sel_i=4'b0100 -> outputs 0; next edge gives sel_err_o=0.
- Registered path: a_i=4'b0100, sel_i=4'b0100 -> y_q_o=1 one edge later. Assert rst_i between edges -> y_q_o=0 and sel_err_o=0 immediately. Deassert -> y_q_o=1 after the next edge.
- Exhaustive sweep of all 256 (a_i, sel_i) pairs -> the five outputs are always equal to each other and to the priority reference.
